// File: rtl/pipe_pkg.sv
// pipe_pkg: mode constants and skid-buffer state encoding shared by the pipeline stage.
// The skid encoding packs the two valid flags as {s_vld, m_vld}.
package pipe_pkg;

    localparam int PIPE_BYPASS = 0;
    localparam int PIPE_FWD    = 1;
    localparam int PIPE_SKID   = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } skid_state_e;

    function automatic bit pipe_mode_ok(input int mode);
        return (mode >= PIPE_BYPASS) && (mode <= PIPE_SKID);
    endfunction

endpackage

// File: rtl/dfflr.sv
// dfflr: load-enable flop with asynchronous active-low reset to zero.
module dfflr #(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          lden,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else if (lden) q <= d;
    end

endmodule

// File: rtl/pipe_reg_stage.sv
// pipe_reg_stage: valid/ready pipeline register, built as bypass, forward register or 2-entry skid buffer.
// Valid flags live in dfflr; data registers reset to RST_VAL and load only when a beat moves in.
module pipe_reg_stage
    import pipe_pkg::*;
#(
    parameter int            DW      = 32,
    parameter int            MODE    = 1,
    parameter logic [DW-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          i_vld,
    output logic          i_rdy,
    input  logic [DW-1:0] i_dat,
    output logic          o_vld,
    input  logic          o_rdy,
    output logic [DW-1:0] o_dat
);

    generate
        if (!pipe_mode_ok(MODE)) begin : g_bad_mode
            $error("pipe_reg_stage: unsupported MODE %0d", MODE);
        end else if (MODE == PIPE_BYPASS) begin : g_bypass
            assign o_vld = i_vld;
            assign o_dat = i_dat;
            assign i_rdy = o_rdy;
        end else if (MODE == PIPE_FWD) begin : g_fwd
            logic          m_vld_q;
            logic          m_vld_d;
            logic [DW-1:0] m_dat_q;
            logic          acc;

            assign i_rdy   = ~flush & (~m_vld_q | o_rdy);
            assign acc     = i_vld & i_rdy;
            assign m_vld_d = flush ? 1'b0 : acc ? 1'b1 : o_rdy ? 1'b0 : m_vld_q;

            dfflr #(.DW(1)) u_m_vld (
                .clk  (clk),
                .rst_n(rst_n),
                .lden (1'b1),
                .d    (m_vld_d),
                .q    (m_vld_q)
            );

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) m_dat_q <= RST_VAL;
                else if (acc) m_dat_q <= i_dat;
            end

            assign o_vld = m_vld_q;
            assign o_dat = m_dat_q;
        end else begin : g_skid
            skid_state_e   st_q;
            skid_state_e   st_d;
            logic [1:0]    flg_q;
            logic [DW-1:0] m_dat_q;
            logic [DW-1:0] m_dat_d;
            logic [DW-1:0] s_dat_q;
            logic          m_ld;
            logic          s_ld;
            logic          acc;

            assign st_q  = skid_state_e'(flg_q);
            // Ready depends only on the registered skid flag, never on o_rdy.
            assign i_rdy = ~flush & ~flg_q[1];
            assign acc   = i_vld & i_rdy;

            always_comb begin
                st_d    = st_q;
                m_ld    = 1'b0;
                s_ld    = 1'b0;
                m_dat_d = i_dat;
                case (st_q)
                    EMPTY: if (acc) begin
                        st_d = ONE;
                        m_ld = 1'b1;
                    end
                    ONE: if (acc && !o_rdy) begin
                        st_d = FULL;
                        s_ld = 1'b1;
                    end else if (acc) begin
                        m_ld = 1'b1;
                    end else if (o_rdy) begin
                        st_d = EMPTY;
                    end
                    FULL: if (o_rdy) begin
                        st_d    = ONE;
                        m_ld    = 1'b1;
                        m_dat_d = s_dat_q;
                    end
                    default: st_d = EMPTY;
                endcase
                if (flush) begin
                    st_d = EMPTY;
                    m_ld = 1'b0;
                end
            end

            dfflr #(.DW(2)) u_flg (
                .clk  (clk),
                .rst_n(rst_n),
                .lden (1'b1),
                .d    (st_d),
                .q    (flg_q)
            );

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    m_dat_q <= RST_VAL;
                    s_dat_q <= RST_VAL;
                end else begin
                    if (m_ld) m_dat_q <= m_dat_d;
                    if (s_ld) s_dat_q <= i_dat;
                end
            end

            assign o_vld = flg_q[0];
            assign o_dat = m_dat_q;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_reg_stage.sv
// tb_pipe_reg_stage: drives bypass, forward and skid instances with shared stimulus and
// checks them against queue-based occupancy models.
module tb_pipe_reg_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush = 1'b0;
    logic       i_vld = 1'b0;
    logic       o_rdy = 1'b0;
    logic [7:0] i_dat = 8'h00;
    logic       rdy0, rdy1, rdy2;
    logic       vld0, vld1, vld2;
    logic [7:0] dat0, dat1, dat2;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    always #5 clk = ~clk;

    pipe_reg_stage #(.DW(8), .MODE(0)) u_byp (
        .clk(clk), .rst_n(rst_n), .flush(flush), .i_vld(i_vld), .i_rdy(rdy0),
        .i_dat(i_dat), .o_vld(vld0), .o_rdy(o_rdy), .o_dat(dat0)
    );

    pipe_reg_stage #(.DW(8), .MODE(1)) u_fwd (
        .clk(clk), .rst_n(rst_n), .flush(flush), .i_vld(i_vld), .i_rdy(rdy1),
        .i_dat(i_dat), .o_vld(vld1), .o_rdy(o_rdy), .o_dat(dat1)
    );

    pipe_reg_stage #(.DW(8), .MODE(2), .RST_VAL(8'hA5)) u_skid (
        .clk(clk), .rst_n(rst_n), .flush(flush), .i_vld(i_vld), .i_rdy(rdy2),
        .i_dat(i_dat), .o_vld(vld2), .o_rdy(o_rdy), .o_dat(dat2)
    );

    // Forward stage holds one beat and can swap it out in the same cycle it is taken.
    function automatic bit exp_rdy1();
        return !flush && (q1.size() == 0 || o_rdy);
    endfunction

    // Skid stage holds up to two beats and takes a new one while it has room.
    function automatic bit exp_rdy2();
        return !flush && q2.size() < 2;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            q1.delete();
            q2.delete();
        end else begin
            bit a1, a2;
            a1 = i_vld && exp_rdy1();
            a2 = i_vld && exp_rdy2();
            if (q1.size() > 0 && o_rdy) void'(q1.pop_front());
            if (q2.size() > 0 && o_rdy) void'(q2.pop_front());
            if (a1) q1.push_back(i_dat);
            if (a2) q2.push_back(i_dat);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (vld2 !== 1'b0) begin n_bad++; $display("FAIL reset_vld2: got %b want 0", vld2); end
        n_cmp++; if (dat2 !== 8'hA5) begin n_bad++; $display("FAIL reset_dat2: got %h want a5", dat2); end
        n_cmp++; if (vld1 !== 1'b0) begin n_bad++; $display("FAIL reset_vld1: got %b want 0", vld1); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (rdy2 !== 1'b1) begin n_bad++; $display("FAIL reset_rdy2: got %b want 1", rdy2); end
        n_cmp++; if (rdy1 !== 1'b1) begin n_bad++; $display("FAIL reset_rdy1: got %b want 1", rdy1); end
        i_vld = 1'b1; i_dat = 8'h77;
        tick();
        i_dat = 8'h78;
        tick();
        i_vld = 1'b0;
        #1;
        n_cmp++; if (vld2 !== 1'b1 || dat2 !== 8'h77) begin n_bad++; $display("FAIL pre_reset_full: got %b/%h want 1/77", vld2, dat2); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (vld2 !== 1'b0) begin n_bad++; $display("FAIL async_vld2: got %b want 0", vld2); end
        n_cmp++; if (dat2 !== 8'hA5) begin n_bad++; $display("FAIL async_dat2: got %h want a5", dat2); end
        n_cmp++; if (rdy2 !== 1'b1) begin n_bad++; $display("FAIL async_rdy2: got %b want 1", rdy2); end
        n_cmp++; if (vld1 !== 1'b0 || dat1 !== 8'h00) begin n_bad++; $display("FAIL async_fwd: got %b/%h want 0/00", vld1, dat1); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (rdy2 !== 1'b1) begin n_bad++; $display("FAIL release_rdy2: got %b want 1", rdy2); end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        i_vld = 1'b1; i_dat = 8'h5A; o_rdy = 1'b0;
        #1;
        n_cmp++; if (vld0 !== 1'b1 || dat0 !== 8'h5A || rdy0 !== 1'b0) begin n_bad++; $display("FAIL bypass: got %b/%h/%b want 1/5a/0", vld0, dat0, rdy0); end
        flush = 1'b1;
        #1;
        n_cmp++; if (vld0 !== 1'b1 || dat0 !== 8'h5A || rdy0 !== 1'b0) begin n_bad++; $display("FAIL bypass_flush: got %b/%h/%b want 1/5a/0", vld0, dat0, rdy0); end
        o_rdy = 1'b1;
        #1;
        n_cmp++; if (rdy0 !== 1'b1) begin n_bad++; $display("FAIL bypass_rdy: got %b want 1", rdy0); end
        flush = 1'b0; i_vld = 1'b0; o_rdy = 1'b0;
    endtask

    task automatic test_stream();
        logic [7:0] e;
        tick();
        o_rdy = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            i_vld = 1'b1; i_dat = 8'(i);
            e = 8'(i - 1);
            @(negedge clk);
            n_cmp++; if (dat0 !== 8'(i) || rdy0 !== 1'b1) begin n_bad++; $display("FAIL stream_byp[%0d]: got %h/%b", i, dat0, rdy0); end
            n_cmp++; if (rdy1 !== 1'b1 || rdy2 !== 1'b1) begin n_bad++; $display("FAIL stream_rdy[%0d]: got %b/%b want 1/1", i, rdy1, rdy2); end
            n_cmp++; if (vld1 !== (i > 1) || (i > 1 && dat1 !== e)) begin n_bad++; $display("FAIL stream_fwd[%0d]: got %b/%h want %b/%h", i, vld1, dat1, i > 1, e); end
            n_cmp++; if (vld2 !== (i > 1) || (i > 1 && dat2 !== e)) begin n_bad++; $display("FAIL stream_skid[%0d]: got %b/%h want %b/%h", i, vld2, dat2, i > 1, e); end
            tick();
        end
        i_vld = 1'b0;
        @(negedge clk);
        n_cmp++; if (vld1 !== 1'b1 || dat1 !== 8'h10 || vld2 !== 1'b1 || dat2 !== 8'h10) begin n_bad++; $display("FAIL stream_last: got %b/%h %b/%h want 1/10", vld1, dat1, vld2, dat2); end
        tick();
        n_cmp++; if (vld1 !== 1'b0 || vld2 !== 1'b0) begin n_bad++; $display("FAIL stream_drain: got %b/%b want 0/0", vld1, vld2); end
    endtask

    task automatic test_skid();
        o_rdy = 1'b1; i_vld = 1'b1; i_dat = 8'h01;
        tick();
        i_dat = 8'h02;
        @(negedge clk);
        n_cmp++; if (vld2 !== 1'b1 || dat2 !== 8'h01) begin n_bad++; $display("FAIL skid_out1: got %b/%h want 1/01", vld2, dat2); end
        tick();
        i_dat = 8'h03; o_rdy = 1'b0;
        @(negedge clk);
        n_cmp++; if (dat2 !== 8'h02 || rdy2 !== 1'b1) begin n_bad++; $display("FAIL skid_take3: got %h/%b want 02/1", dat2, rdy2); end
        tick();
        i_vld = 1'b0;
        @(negedge clk);
        n_cmp++; if (vld2 !== 1'b1 || dat2 !== 8'h02 || rdy2 !== 1'b0) begin n_bad++; $display("FAIL skid_full: got %b/%h/%b want 1/02/0", vld2, dat2, rdy2); end
        tick();
        n_cmp++; if (vld2 !== 1'b1 || dat2 !== 8'h02 || rdy2 !== 1'b0) begin n_bad++; $display("FAIL skid_hold: got %b/%h/%b want 1/02/0", vld2, dat2, rdy2); end
        o_rdy = 1'b1;
        tick();
        n_cmp++; if (vld2 !== 1'b1 || dat2 !== 8'h03 || rdy2 !== 1'b1) begin n_bad++; $display("FAIL skid_out3: got %b/%h/%b want 1/03/1", vld2, dat2, rdy2); end
        tick();
        n_cmp++; if (vld2 !== 1'b0) begin n_bad++; $display("FAIL skid_empty: got %b want 0", vld2); end
    endtask

    task automatic test_ready_path();
        logic prev;
        i_vld = 1'b1;
        for (int i = 0; i < 40; i++) begin
            prev = rdy2;
            o_rdy = ~o_rdy;
            i_dat = 8'($urandom);
            #1;
            n_cmp++; if (rdy2 !== prev) begin n_bad++; $display("FAIL rdy_comb[%0d]: got %b want %b", i, rdy2, prev); end
            @(negedge clk);
            n_cmp++; if (rdy2 !== exp_rdy2() || vld2 !== (q2.size() > 0) || (q2.size() > 0 && dat2 !== q2[0])) begin n_bad++; $display("FAIL rdy_path[%0d]: got %b/%b/%h", i, rdy2, vld2, dat2); end
            tick();
        end
        i_vld = 1'b0; o_rdy = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_flush();
        o_rdy = 1'b0; i_vld = 1'b1; i_dat = 8'h11;
        tick();
        i_dat = 8'h22;
        tick();
        i_vld = 1'b0;
        @(negedge clk);
        n_cmp++; if (vld2 !== 1'b1 || dat2 !== 8'h11 || rdy2 !== 1'b0) begin n_bad++; $display("FAIL flush_pre: got %b/%h/%b want 1/11/0", vld2, dat2, rdy2); end
        tick();
        flush = 1'b1; i_vld = 1'b1; i_dat = 8'h44;
        @(negedge clk);
        n_cmp++; if (rdy2 !== 1'b0 || rdy1 !== 1'b0) begin n_bad++; $display("FAIL flush_rdy: got %b/%b want 0/0", rdy2, rdy1); end
        tick();
        flush = 1'b0; i_vld = 1'b0;
        @(negedge clk);
        n_cmp++; if (vld2 !== 1'b0 || vld1 !== 1'b0) begin n_bad++; $display("FAIL flush_vld: got %b/%b want 0/0", vld2, vld1); end
        n_cmp++; if (dat2 !== 8'h11) begin n_bad++; $display("FAIL flush_hold: got %h want 11", dat2); end
        tick();
        i_vld = 1'b1; i_dat = 8'h33;
        tick();
        i_vld = 1'b0;
        @(negedge clk);
        n_cmp++; if (vld2 !== 1'b1 || dat2 !== 8'h33) begin n_bad++; $display("FAIL flush_next: got %b/%h want 1/33", vld2, dat2); end
        tick();
        o_rdy = 1'b1;
        tick();
        n_cmp++; if (vld2 !== 1'b0) begin n_bad++; $display("FAIL flush_drain: got %b want 0", vld2); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            i_vld = 1'($urandom_range(0, 1));
            i_dat = 8'($urandom);
            o_rdy = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            n_cmp++; if (rdy1 !== exp_rdy1() || vld1 !== (q1.size() > 0) || (q1.size() > 0 && dat1 !== q1[0])) begin n_bad++; $display("FAIL rand_fwd[%0d]: got %b/%b/%h want %b/%b", i, rdy1, vld1, dat1, exp_rdy1(), q1.size() > 0); end
            n_cmp++; if (rdy2 !== exp_rdy2() || vld2 !== (q2.size() > 0) || (q2.size() > 0 && dat2 !== q2[0])) begin n_bad++; $display("FAIL rand_skid[%0d]: got %b/%b/%h want %b/%b", i, rdy2, vld2, dat2, exp_rdy2(), q2.size() > 0); end
            tick();
        end
        flush = 1'b0; i_vld = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_stream();
        test_skid();
        test_ready_path();
        test_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
